pipeline_hazard_ctl: RTL and testbench

Central stall/flush controller for the 5-stage MIPS pipeline.
- Decides each cycle whether PC, IF/ID and ID/EX advance, hold, bubble or flush.
- Handles load-use hazards, taken-branch squash and multi-cycle data-memory waits, with a timeout error trap.
- Sits beside the decode stage. Drives the write/flush enables of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/pipeline_pkg.sv | 25 ++
 rtl/pipeline_hazard_ctl_hazard_detect.sv | 45 ++++
 rtl/pipeline_hazard_ctl.sv | 178 +++++++++++++++++
 tb/tb_pipeline_hazard_ctl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Definitions shared by the pipeline hazard controller and its sub-blocks:
//   - state_t      : hazard controller FSM state encoding
//   - REG_W        : register-index width (MIPS: 32 registers)
//   - WB_W/M_W/EX_W: widths of the pipeline control bundles
//   - M_MEMREAD_BIT: position of MemRead inside the M bundle {Branch, MemRead, MemWrite}
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam int REG_W = 5;

    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    localparam int M_MEMREAD_BIT = 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_hazard_ctl_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use detector. Flags when the instruction in EX
// is a load whose destination is read by the instruction in ID.
//   ex_memread : ID/EX MemRead control bit
//   ex_rt      : load destination register (ID/EX rt)
//   id_rs      : IF/ID rs source field
//   id_rt      : IF/ID rt source field
//   id_uses_rt : the ID instruction actually reads rt as a source
//   load_use   : hazard present, one bubble required
// ---------------------------------------------------------------------------
import pipeline_pkg::*;

module hazard_detect (
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             load_use
);

    logic [REG_W-1:0] rs_bit_eq;
    logic [REG_W-1:0] rt_bit_eq;

    genvar gi;
    generate
        for (gi = 0; gi < REG_W; gi++) begin : g_cmp
            assign rs_bit_eq[gi] = ~(ex_rt[gi] ^ id_rs[gi]);
            assign rt_bit_eq[gi] = ~(ex_rt[gi] ^ id_rt[gi]);
        end
    endgenerate

    logic rs_match;
    logic rt_match;
    logic dest_nonzero;

    assign rs_match     = &rs_bit_eq;
    assign rt_match     = (&rt_bit_eq) & id_uses_rt;
    // $zero is hardwired, so a load "into" it never produces a real value to wait for.
    assign dest_nonzero = |ex_rt;

    assign load_use = ex_memread & dest_nonzero & (rs_match | rt_match);

endmodule

// File: rtl/pipeline_hazard_ctl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctl
// Central stall/flush controller for the 5-stage MIPS pipeline. Each cycle it
// decides whether PC, IF/ID, ID/EX, EX/MEM and MEM/WB advance, hold, bubble or
// flush. Handles load-use hazards, taken-branch squash (branch resolved in
// MEM) and multi-cycle data-memory waits with a timeout error trap.
//
// Parameters:
//   MEM_TIMEOUT : consecutive frozen memory-wait cycles before ERROR (>=2)
//   CNT_W       : width of the saturating stall_cycles counter
// Ports:
//   clk, rst (synchronous, active-low)
//   id_rs, id_rt, id_uses_rt      : source operands of the instr in ID
//   ex_memread, ex_rt             : load info of the instr in EX
//   mem_branch_taken              : branch in MEM resolved taken
//   mem_req, mem_ready            : data-memory handshake of the instr in MEM
//   pc_write .. memwb_bubble      : pipeline register enables / clears
//   err                           : sticky memory-timeout error
//   stall_cycles                  : cycles with pc_write==0 (saturating)
// Enables are combinational from state + inputs so a hazard acts in the
// cycle it is detected; state and counters are registered.
// ---------------------------------------------------------------------------
import pipeline_pkg::*;

module pipeline_hazard_ctl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             mem_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             exmem_flush,
    output logic             memwb_bubble,
    output logic             err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              err_reg, err_next;
    logic [CNT_W-1:0]  stall_cycles_reg;

    logic load_use;
    logic freeze;
    logic run_eval;

    hazard_detect u_hazard_detect (
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .load_use   (load_use)
    );

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        err_next      = err_reg;
        freeze        = 1'b0;
        run_eval      = 1'b0;

        unique case (state_reg)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    freeze        = 1'b1;
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end else begin
                    run_eval = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    // Access completes: the pipeline advances this very cycle,
                    // so branch and load-use must be honoured now.
                    state_next    = RUN;
                    wait_cnt_next = '0;
                    run_eval      = 1'b1;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt_reg == WAIT_LAST) begin
                        state_next = ERROR;
                        err_next   = 1'b1;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                    end
                end
            end
            ERROR: begin
                freeze = 1'b1;
            end
            default: begin
                // Unreachable encoding: hold the pipeline and resynchronise.
                freeze     = 1'b1;
                state_next = RUN;
            end
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b1;
        exmem_flush  = 1'b0;
        memwb_bubble = 1'b0;

        if (freeze) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (run_eval) begin
            if (mem_branch_taken) begin
                // Squash the three younger instructions; this also removes
                // any dependent instruction, so load-use is moot.
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                exmem_flush = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end

        if (!rst) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            ifid_flush   = 1'b1;
            exmem_flush  = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg        <= RUN;
            wait_cnt_reg     <= '0;
            err_reg          <= 1'b0;
            stall_cycles_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            err_reg      <= err_next;
            if (!pc_write && (stall_cycles_reg != {CNT_W{1'b1}})) begin
                stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
            end
        end
    end

    assign err          = err_reg;
    assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctl
// Directed bench for pipeline_hazard_ctl. Inputs change 1 time unit after a
// rising edge; outputs are compared mid-cycle. The 8 enable outputs are packed
// as {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
//     exmem_write, exmem_flush, memwb_bubble}.
// A second instance with CNT_W=4 exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctl;

    localparam logic [7:0] C_NORMAL  = 8'b1101_0100;
    localparam logic [7:0] C_RESET   = 8'b0010_1011;
    localparam logic [7:0] C_FREEZE  = 8'b0000_0001;
    localparam logic [7:0] C_LOADUSE = 8'b0001_1100;
    localparam logic [7:0] C_BRANCH  = 8'b1111_1110;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_memread, mem_branch_taken, mem_req, mem_ready;
    logic       pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
    logic       exmem_write, exmem_flush, memwb_bubble, err;
    logic [31:0] stall_cycles;

    logic       rst2, mem_req2, mem_ready2;
    logic       pc_write2, ifid_write2, ifid_flush2, idex_write2, idex_bubble2;
    logic       exmem_write2, exmem_flush2, memwb_bubble2, err2;
    logic [3:0] stall_cycles2;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt),
        .mem_branch_taken(mem_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_bubble(idex_bubble),
        .exmem_write(exmem_write), .exmem_flush(exmem_flush),
        .memwb_bubble(memwb_bubble), .err(err), .stall_cycles(stall_cycles)
    );

    pipeline_hazard_ctl #(.MEM_TIMEOUT(16), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst2),
        .id_rs(5'd0), .id_rt(5'd0), .id_uses_rt(1'b0),
        .ex_memread(1'b0), .ex_rt(5'd0),
        .mem_branch_taken(1'b0),
        .mem_req(mem_req2), .mem_ready(mem_ready2),
        .pc_write(pc_write2), .ifid_write(ifid_write2), .ifid_flush(ifid_flush2),
        .idex_write(idex_write2), .idex_bubble(idex_bubble2),
        .exmem_write(exmem_write2), .exmem_flush(exmem_flush2),
        .memwb_bubble(memwb_bubble2), .err(err2), .stall_cycles(stall_cycles2)
    );

    function automatic logic [7:0] ctl();
        return {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                exmem_write, exmem_flush, memwb_bubble};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
            $display("check %-16s observed=%h expected=%h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_memread = 1'b0; ex_rt = 5'd0;
        mem_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        rst2 = 1'b0; mem_req2 = 1'b0; mem_ready2 = 1'b0;

        // Reset state
        tick();
        #1;
        check("reset_ctl", 32'(ctl()), 32'(C_RESET));
        check("reset_stall", stall_cycles, 32'd0);
        check("reset_err", 32'(err), 32'd0);
        rst = 1'b1;
        #1;
        check("run_default", 32'(ctl()), 32'(C_NORMAL));

        // Load-use on rs: one bubble, then normal with the load in MEM
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        #1;
        check("lu_rs", 32'(ctl()), 32'(C_LOADUSE));
        tick();
        ex_memread = 1'b0;
        #1;
        check("lu_after", 32'(ctl()), 32'(C_NORMAL));
        check("lu_stall", stall_cycles, 32'd1);

        // rt dependency only counts when rt is really a source
        ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd0; id_rt = 5'd9; id_uses_rt = 1'b0;
        #1;
        check("rt_unused", 32'(ctl()), 32'(C_NORMAL));
        id_uses_rt = 1'b1;
        #1;
        check("rt_used", 32'(ctl()), 32'(C_LOADUSE));
        tick();
        check("rt_stall", stall_cycles, 32'd2);
        // $zero destination never stalls even though rs matches
        ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        #1;
        check("zero_reg", 32'(ctl()), 32'(C_NORMAL));
        tick();
        check("zero_stall", stall_cycles, 32'd2);

        // Branch wins over a concurrent load-use hazard
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; mem_branch_taken = 1'b1;
        #1;
        check("br_lu", 32'(ctl()), 32'(C_BRANCH));
        tick();
        check("br_stall", stall_cycles, 32'd2);
        clear_inputs();

        // Memory wait: mem_ready low for 4 cycles gives 4 frozen cycles
        reset_pulse();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("mw_freeze%0d", i), 32'(ctl()), 32'(C_FREEZE));
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("mw_release", 32'(ctl()), 32'(C_NORMAL));
        tick();
        mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        check("mw_run", 32'(ctl()), 32'(C_NORMAL));
        check("mw_stall", stall_cycles, 32'd4);

        // Release cycle honours a pending load-use in the same cycle
        mem_req = 1'b1; mem_ready = 1'b0;
        tick();
        mem_ready = 1'b1; ex_memread = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
        #1;
        check("mw_rel_lu", 32'(ctl()), 32'(C_LOADUSE));
        tick();
        clear_inputs();
        #1;
        check("mw_rel_run", 32'(ctl()), 32'(C_NORMAL));
        check("mw_rel_stall", stall_cycles, 32'd6);

        // Timeout: 16 frozen cycles then ERROR, sticky until reset
        reset_pulse();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            check($sformatf("to_frz%0d", i), {31'd0, err}, 32'd0);
            tick();
        end
        #1;
        check("to_err", 32'(err), 32'd1);
        check("to_ctl", 32'(ctl()), 32'(C_FREEZE));
        check("to_stall", stall_cycles, 32'd16);
        mem_req = 1'b0; mem_ready = 1'b1; mem_branch_taken = 1'b1;
        #1;
        check("err_ignore_in", 32'(ctl()), 32'(C_FREEZE));
        tick();
        check("err_sticky", 32'(err), 32'd1);
        check("err_stall", stall_cycles, 32'd17);
        clear_inputs();
        rst = 1'b0;
        #1;
        check("err_rst_ctl", 32'(ctl()), 32'(C_RESET));
        tick();
        rst = 1'b1;
        #1;
        check("err_clr", 32'(err), 32'd0);
        check("err_clr_stall", stall_cycles, 32'd0);
        check("err_clr_run", 32'(ctl()), 32'(C_NORMAL));

        // Saturation on a 4-bit counter: 20 frozen cycles stop at 15
        tick();
        rst2 = 1'b1; mem_req2 = 1'b1; mem_ready2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check("sat_stall", 32'(stall_cycles2), 32'd15);
        check("sat_err", 32'(err2), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
